// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Single-outstanding-request instruction fetch unit. It requests the word
//   at the current PC, captures it when memory answers, and holds it for the
//   decoder until the decoder consumes it. At the consume edge the next PC
//   is chosen (sequential or branch target) and the retired count advances.
//
// Ports:
//   i_clk                  clock, all state updates on the rising edge
//   i_reset                synchronous, active-high reset
//   o_imemAddress   [63:0] instruction memory byte address (current PC)
//   o_imemRequest          fetch request to instruction memory
//   i_imemReady            memory response, i_imemData valid this cycle
//   i_imemData      [31:0] instruction word from memory
//   o_instruction   [31:0] held instruction word for the decoder
//   o_instructionValid     held word is fetched and not yet consumed
//   o_pcOut         [63:0] PC of the held instruction
//   i_stall                decoder not ready, held word is not consumed
//   i_branch               conditional-branch control
//   i_unconditionalBranch  unconditional-branch control
//   i_zero                 ALU zero flag for the conditional branch
//   i_branchOffset  [63:0] signed word offset, already sign-extended
//   o_retiredCount  [31:0] count of consumed instructions (wraps)
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [63:0] o_imemAddress,
  output logic        o_imemRequest,
  input  logic        i_imemReady,
  input  logic [31:0] i_imemData,
  output logic [31:0] o_instruction,
  output logic        o_instructionValid,
  output logic [63:0] o_pcOut,
  input  logic        i_stall,
  input  logic        i_branch,
  input  logic        i_unconditionalBranch,
  input  logic        i_zero,
  input  logic [63:0] i_branchOffset,
  output logic [31:0] o_retiredCount
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        w_capture;
  logic        w_consume;
  logic        w_taken;
  logic [63:0] w_nextPc;

  logic [63:0] r_pc;
  logic [31:0] r_instruction;
  logic [63:0] r_pcOut;
  logic        r_instructionValid;
  logic [31:0] r_retiredCount;

  // The branch decision is only acted on at the consume edge; the offset is
  // in words, so it is scaled to bytes before being added to the held PC.
  assign w_taken  = i_unconditionalBranch | (i_branch & i_zero);
  assign w_nextPc = r_pcOut + (w_taken ? (i_branchOffset << 2) : 64'd4);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic plus the capture/consume strobes for the datapath.
  // A response in HOLD is ignored because no request is outstanding.
  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      FETCH: begin
        if (i_imemReady) begin
          w_capture   = 1'b1;
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (!i_stall) begin
          w_consume   = 1'b1;
          w_nextState = FETCH;
        end
      end
      default: w_nextState = FETCH;
    endcase
  end

  // Datapath registers. The PC only moves at the consume edge, so the
  // request address stays stable while memory is waited on.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc               <= RESET_PC;
      r_instruction      <= 32'h0;
      r_pcOut            <= RESET_PC;
      r_instructionValid <= 1'b0;
      r_retiredCount     <= 32'h0;
    end else if (w_capture) begin
      r_instruction      <= i_imemData;
      r_pcOut            <= r_pc;
      r_instructionValid <= 1'b1;
    end else if (w_consume) begin
      r_pc               <= w_nextPc;
      r_instructionValid <= 1'b0;
      r_retiredCount     <= r_retiredCount + 32'd1;
    end
  end

  // The request is suppressed combinationally while reset is held so no
  // fetch is issued during a reset cycle, even mid-operation.
  assign o_imemRequest      = (r_state == FETCH) && !i_reset;
  assign o_imemAddress      = r_pc;
  assign o_instruction      = r_instruction;
  assign o_instructionValid = r_instructionValid;
  assign o_pcOut            = r_pcOut;
  assign o_retiredCount     = r_retiredCount;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Self-checking bench for instruction_fetch. Directed scenarios cover reset,
// sequential fetch, memory wait with decoder stall, branches, PC and count
// wrap and reset mid-fetch; a randomized run is checked against a
// transaction-level reference model of the fetch unit.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReady;
  logic [31:0] imemData;
  logic        stall;
  logic        branch;
  logic        unconditionalBranch;
  logic        zero;
  logic [63:0] branchOffset;

  logic [63:0] imemAddress,      wImemAddress;
  logic        imemRequest,      wImemRequest;
  logic [31:0] instruction,      wInstruction;
  logic        instructionValid, wInstructionValid;
  logic [63:0] pcOut,            wPcOut;
  logic [31:0] retiredCount,     wRetiredCount;

  int nCompared   = 0;
  int nMismatched = 0;

  // Main DUT starts at PC 0; the second one starts just below the 64-bit
  // wrap point and shares the same stimulus.
  instruction_fetch #(.RESET_PC(64'h0)) dut (
    .i_clk(clk), .i_reset(reset),
    .o_imemAddress(imemAddress), .o_imemRequest(imemRequest),
    .i_imemReady(imemReady), .i_imemData(imemData),
    .o_instruction(instruction), .o_instructionValid(instructionValid),
    .o_pcOut(pcOut), .i_stall(stall), .i_branch(branch),
    .i_unconditionalBranch(unconditionalBranch), .i_zero(zero),
    .i_branchOffset(branchOffset), .o_retiredCount(retiredCount)
  );

  instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dutWrap (
    .i_clk(clk), .i_reset(reset),
    .o_imemAddress(wImemAddress), .o_imemRequest(wImemRequest),
    .i_imemReady(imemReady), .i_imemData(imemData),
    .o_instruction(wInstruction), .o_instructionValid(wInstructionValid),
    .o_pcOut(wPcOut), .i_stall(stall), .i_branch(branch),
    .i_unconditionalBranch(unconditionalBranch), .i_zero(zero),
    .i_branchOffset(branchOffset), .o_retiredCount(wRetiredCount)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rdy, input logic [31:0] data,
                               input logic stl, input logic br,
                               input logic unc, input logic z,
                               input logic [63:0] off);
    imemReady           = rdy;
    imemData            = data;
    stall               = stl;
    branch              = br;
    unconditionalBranch = unc;
    zero                = z;
    branchOffset        = off;
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // One full sequential instruction: fetch with immediate response, then
  // consume without branching.
  task automatic fetchAndConsume(input logic [31:0] data);
    applyStimulus(1'b1, data, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    tick();
    nCompared++;
    if (imemRequest !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_request got %0b want 0", imemRequest);
    end
    nCompared++;
    if (instructionValid !== 1'b0 || instruction !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_instr got v=%0b i=%h want v=0 i=0", instructionValid, instruction);
    end
    nCompared++;
    if (pcOut !== 64'h0 || imemAddress !== 64'h0 || retiredCount !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_regs got pcOut=%h addr=%h cnt=%0d want 0/0/0", pcOut, imemAddress, retiredCount);
    end
    nCompared++;
    if (wImemAddress !== 64'hFFFF_FFFF_FFFF_FFFC || wPcOut !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      nMismatched++;
      $display("[TB] FAIL reset_pc_param got addr=%h pcOut=%h want fffffffffffffffc", wImemAddress, wPcOut);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    nCompared++;
    if (imemRequest !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL reset_release_request got %0b want 1", imemRequest);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] data;
    applyReset();
    for (int i = 0; i < 3; i++) begin
      data = 32'h1000_0000 + 32'(i);
      nCompared++;
      if (imemRequest !== 1'b1 || imemAddress !== 64'(4 * i)) begin
        nMismatched++;
        $display("[TB] FAIL seq_request[%0d] got req=%0b addr=%h want 1/%h", i, imemRequest, imemAddress, 64'(4 * i));
      end
      applyStimulus(1'b1, data, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
      tick();
      nCompared++;
      if (imemRequest !== 1'b0 || instructionValid !== 1'b1 || instruction !== data || pcOut !== 64'(4 * i)) begin
        nMismatched++;
        $display("[TB] FAIL seq_capture[%0d] got req=%0b v=%0b i=%h pc=%h want 0/1/%h/%h", i, imemRequest, instructionValid, instruction, pcOut, data, 64'(4 * i));
      end
      tick();
    end
    nCompared++;
    if (retiredCount !== 32'd3 || imemAddress !== 64'd12) begin
      nMismatched++;
      $display("[TB] FAIL seq_count got cnt=%0d addr=%h want 3/c", retiredCount, imemAddress);
    end
  endtask

  task automatic test_wait_stall();
    applyReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
      tick();
      nCompared++;
      if (imemRequest !== 1'b1 || imemAddress !== 64'h0 || instructionValid !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL wait_stable[%0d] got req=%0b addr=%h v=%0b want 1/0/0", i, imemRequest, imemAddress, instructionValid);
      end
    end
    applyStimulus(1'b1, 32'h8B02_0020, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    // Memory still answering during HOLD must be ignored.
    applyStimulus(1'b1, 32'hFFFF_0000, 1'b1, 1'b1, 1'b1, 1'b1, 64'h40);
    for (int i = 0; i < 3; i++) begin
      nCompared++;
      if (instructionValid !== 1'b1 || instruction !== 32'h8B02_0020 || imemAddress !== 64'h0 || retiredCount !== 32'h0) begin
        nMismatched++;
        $display("[TB] FAIL stall_hold[%0d] got v=%0b i=%h addr=%h cnt=%0d want 1/8b020020/0/0", i, instructionValid, instruction, imemAddress, retiredCount);
      end
      if (i < 2) tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    nCompared++;
    if (imemAddress !== 64'h4 || retiredCount !== 32'd1 || instructionValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL stall_release got addr=%h cnt=%0d v=%0b want 4/1/0", imemAddress, retiredCount, instructionValid);
    end
  endtask

  task automatic test_cond_branch();
    applyReset();
    for (int i = 0; i < 4; i++) fetchAndConsume(32'h0);
    applyStimulus(1'b1, 32'hB400_0040, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    nCompared++;
    if (imemAddress !== 64'h08) begin
      nMismatched++;
      $display("[TB] FAIL cbranch_taken got %h want 8", imemAddress);
    end
    for (int i = 0; i < 2; i++) fetchAndConsume(32'h0);
    applyStimulus(1'b1, 32'hB400_0040, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    nCompared++;
    if (imemAddress !== 64'h14) begin
      nMismatched++;
      $display("[TB] FAIL cbranch_not_taken got %h want 14", imemAddress);
    end
  endtask

  task automatic test_uncond_branch();
    applyReset();
    applyStimulus(1'b1, 32'h1400_0100, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h100);
    tick();
    nCompared++;
    if (imemAddress !== 64'h400) begin
      nMismatched++;
      $display("[TB] FAIL ubranch got %h want 400", imemAddress);
    end
    // Both controls set with zero low, offset 0: taken, re-fetches same PC.
    applyStimulus(1'b1, 32'h1400_0000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    tick();
    nCompared++;
    if (imemAddress !== 64'h400 || retiredCount !== 32'd2) begin
      nMismatched++;
      $display("[TB] FAIL ubranch_refetch got addr=%h cnt=%0d want 400/2", imemAddress, retiredCount);
    end
  endtask

  task automatic test_wrap();
    applyReset();
    fetchAndConsume(32'h0);
    nCompared++;
    if (wImemAddress !== 64'h0) begin
      nMismatched++;
      $display("[TB] FAIL pc_wrap got %h want 0", wImemAddress);
    end
    force dutWrap.r_retiredCount = 32'hFFFF_FFFF;
    #1;
    release dutWrap.r_retiredCount;
    #1;
    fetchAndConsume(32'h0);
    nCompared++;
    if (wRetiredCount !== 32'h0 || wImemAddress !== 64'h4) begin
      nMismatched++;
      $display("[TB] FAIL count_wrap got cnt=%h addr=%h want 0/4", wRetiredCount, wImemAddress);
    end
  endtask

  task automatic test_reset_mid();
    applyReset();
    fetchAndConsume(32'h0);
    fetchAndConsume(32'h0);
    reset = 1'b1;
    applyStimulus(1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 1'b1, 64'h20);
    nCompared++;
    if (imemRequest !== 1'b0 || instructionValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL rstmid_same_cycle got req=%0b v=%0b want 0/0", imemRequest, instructionValid);
    end
    tick();
    nCompared++;
    if (instructionValid !== 1'b0 || imemAddress !== 64'h0 || retiredCount !== 32'h0 || pcOut !== 64'h0) begin
      nMismatched++;
      $display("[TB] FAIL rstmid_state got v=%0b addr=%h cnt=%0d pc=%h want 0/0/0/0", instructionValid, imemAddress, retiredCount, pcOut);
    end
    // Reset while holding an unconsumed word discards it.
    reset = 1'b0;
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h80);
    tick();
    reset = 1'b0;
    #1;
    nCompared++;
    if (instructionValid !== 1'b0 || instruction !== 32'h0 || imemAddress !== 64'h0 || retiredCount !== 32'h0 || imemRequest !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL rstmid_hold got v=%0b i=%h addr=%h cnt=%0d req=%0b want 0/0/0/0/1", instructionValid, instruction, imemAddress, retiredCount, imemRequest);
    end
  endtask

  // Transaction-level model: an instruction is either waiting in memory or
  // held for the decoder; consuming it retires it and picks the next PC.
  task automatic test_random();
    bit          mHolding;
    logic [63:0] mPc, mPcOut, off;
    logic [31:0] mInstr, mCount, data;
    bit          rst, rdy, stl, br, unc, z, taken;
    int          errsBefore;
    applyReset();
    mHolding = 0; mPc = 64'h0; mPcOut = 64'h0; mInstr = 32'h0; mCount = 32'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst  = ($urandom_range(0, 49) == 0);
      rdy  = ($urandom_range(0, 2) != 0);
      stl  = ($urandom_range(0, 2) == 0);
      br   = $urandom_range(0, 1) == 1;
      unc  = ($urandom_range(0, 3) == 0);
      z    = $urandom_range(0, 1) == 1;
      data = $urandom;
      if ($urandom_range(0, 3) == 0) off = {$urandom, $urandom};
      else off = 64'($signed(32'($urandom_range(0, 64)) - 32'd32));
      reset = rst;
      applyStimulus(rdy, data, stl, br, unc, z, off);
      errsBefore = nMismatched;
      nCompared++;
      if (imemRequest !== (!mHolding && !rst) || imemAddress !== mPc) begin
        nMismatched++;
        $display("[TB] FAIL rand_request[%0d] got req=%0b addr=%h want %0b/%h", cyc, imemRequest, imemAddress, !mHolding && !rst, mPc);
      end
      nCompared++;
      if (instructionValid !== mHolding || instruction !== mInstr || pcOut !== mPcOut) begin
        nMismatched++;
        $display("[TB] FAIL rand_held[%0d] got v=%0b i=%h pc=%h want %0b/%h/%h", cyc, instructionValid, instruction, pcOut, mHolding, mInstr, mPcOut);
      end
      nCompared++;
      if (retiredCount !== mCount) begin
        nMismatched++;
        $display("[TB] FAIL rand_count[%0d] got %0d want %0d", cyc, retiredCount, mCount);
      end
      if (nMismatched - errsBefore > 0 && nMismatched > 20) begin
        $display("[TB] FAIL rand_abort too many errors, stopping random run");
        break;
      end
      if (rst) begin
        mHolding = 0; mPc = 64'h0; mPcOut = 64'h0; mInstr = 32'h0; mCount = 32'h0;
      end else if (!mHolding && rdy) begin
        mHolding = 1; mInstr = data; mPcOut = mPc;
      end else if (mHolding && !stl) begin
        taken    = unc || (br && z);
        mPc      = mPcOut + (taken ? off * 64'd4 : 64'd4);
        mHolding = 0;
        mCount   = mCount + 32'd1;
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    test_reset();
    test_sequential();
    test_wait_stall();
    test_cond_branch();
    test_uncond_branch();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout simulation did not complete within limit");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imemAddress  output  64  instruction memory byte address, equal to current PC.
REQ-006 imemRequest  output  1  fetch request to instruction memory.
REQ-007 imemReady  input  1  memory response; imemData valid this cycle.
REQ-008 imemData  input  32  instruction word from memory.
REQ-009 instruction  output  32  held instruction word driven to the decoder.
REQ-010 instructionValid  output  1  instruction holds a fetched, unconsumed word.
REQ-011 pcOut  output  64  PC of the held instruction.
REQ-012 stall  input  1  decoder not ready; the held instruction is not consumed.
REQ-013 branch  input  1  conditional-branch control from the decoder.
REQ-014 unconditionalBranch  input  1  unconditional-branch control from the decoder.
REQ-015 zero  input  1  ALU zero flag for the conditional branch.
REQ-016 branchOffset  input  64  signed word offset, already sign-extended.
REQ-017 retiredCount  output  32  count of consumed instructions.

Function
REQ-018 FSM states: FETCH and HOLD only.
  - Reset state is FETCH.
REQ-019 FETCH outputs: imemRequest=1, imemAddress=PC, instructionValid=0.
REQ-020 FETCH, edge with imemReady=1:
  - instruction<=imemData, pcOut<=PC, instructionValid<=1.
  - Go to HOLD; imemRequest is 0 from the next cycle.
REQ-021 FETCH, imemReady=0: hold imemRequest and imemAddress stable, no state change.
REQ-022 imemReady while imemRequest=0 (HOLD or reset) is ignored; no register changes.
REQ-023 HOLD, stall=1: instruction, pcOut, PC, instructionValid and retiredCount all unchanged.
REQ-024 HOLD, stall=0: the held instruction is consumed at that edge.
  - PC<=nextPC, instructionValid<=0, retiredCount<=retiredCount+1, go to FETCH.
REQ-025 taken = unconditionalBranch OR (branch AND zero); branch inputs are sampled only at the consume edge and ignored otherwise.
REQ-026 nextPC selection:
  - taken: pcOut + (branchOffset << 2).
  - not taken: pcOut + 4.
  - Arithmetic is modulo 2^64; the PC wraps silently.
REQ-027 unconditionalBranch=1 with branch=1: taken, regardless of zero.
REQ-028 Negative branchOffset moves PC backward (two's complement).
  - branchOffset=0 with taken re-fetches pcOut.
REQ-029 retiredCount wraps 32'hFFFFFFFF -> 0 without a flag.
REQ-030 Latency: minimum 2 cycles per instruction.
  - Request cycle plus consume cycle, with imemReady=1 in the first FETCH cycle and stall=0.
REQ-031 At most one outstanding request; PC changes only at the consume edge.

Reset
REQ-032 Reset outputs and state:
  - PC=RESET_PC, state=FETCH.
  - instruction=0, instructionValid=0, pcOut=RESET_PC, retiredCount=0.
REQ-033 imemRequest=0 during any cycle with reset=1; asserted the first cycle after reset deasserts.
REQ-034 Reset mid-operation:
  - Dominates imemReady, stall and branch inputs in the same cycle.
  - Abandons any pending request; the held instruction is discarded.

Verification
REQ-035 Sequential fetch:
  - Stimulus: RESET_PC=0, imemReady=1 always, stall=0, no branches.
  - Response: imemAddress sequence 0,4,8,12 on request cycles; retiredCount=3 after third consume.
REQ-036 Memory wait and stall:
  - Stimulus: imemReady low 3 cycles, then high with imemData=32'h8B020020; hold stall=1 for 2 cycles.
  - Response: address stable through the wait; instruction=32'h8B020020, instructionValid=1 held for 2 cycles; PC advances by 4 only after stall=0.
REQ-037 Conditional branch:
  - Stimulus: pcOut=64'h10, branch=1, branchOffset=-2.
  - Response: zero=1 gives next imemAddress=64'h08; zero=0 gives 64'h14.
REQ-038 Unconditional branch:
  - Stimulus: unconditionalBranch=1, zero=0, branchOffset=64'h100 at pcOut=0.
  - Response: next imemAddress=64'h400.
REQ-039 Wrap and count:
  - Stimulus: RESET_PC=64'hFFFFFFFFFFFFFFFC, sequential fetch.
  - Response: second address=64'h0; with retiredCount preloaded to 32'hFFFFFFFF via a forced run, it wraps to 0.
REQ-040 Reset mid-fetch:
  - Stimulus: reset=1 in the same cycle as imemReady=1.
  - Response: instructionValid=0, imemRequest=0 that cycle, PC=RESET_PC, retiredCount=0.
